// File: rtl/cypher_stream_reader.sv
// cypher_stream_reader
//   Drain side of the ciphertext collection path. On load_i in IDLE the complete ciphertext
//   buffer (and optionally the tag) is snapshotted, after which the words are streamed out one
//   per valid/ready handshake. The upstream collection register is free again as soon as the
//   snapshot is taken.
//
// Optional feature macro: CYPHER_TAG_OUT_EN
//   defined   : after the NB_BLOCKS cipher words, tag_i[127:64] then tag_i[63:0] are streamed.
//   undefined : tag_i is ignored and no tag register exists.
//
// Ports
//   clock_i   : system clock, rising edge
//   reset_i   : synchronous, active-high reset
//   load_i    : snapshot request, accepted only in IDLE
//   cypher_i  : NB_BLOCKS ciphertext words, word k at [64k+63:64k], word 0 streamed first
//   tag_i     : ASCON tag, [127:64] streamed first (only with CYPHER_TAG_OUT_EN)
//   ready_i   : downstream ready
//   data_o    : current output word
//   valid_o   : data_o holds a valid word
//   last_o    : current word is the final word of the message
//   busy_o    : high from load acceptance through the done cycle
//   done_o    : one-cycle pulse after the final transfer
module cypher_stream_reader #(
  parameter int unsigned NB_BLOCKS = 4,
  parameter int unsigned WORD_W    = 64
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic                        load_i,
  input  logic [NB_BLOCKS*WORD_W-1:0] cypher_i,
  input  logic [127:0]                tag_i,
  input  logic                        ready_i,
  output logic [WORD_W-1:0]           data_o,
  output logic                        valid_o,
  output logic                        last_o,
  output logic                        busy_o,
  output logic                        done_o
);

`ifdef CYPHER_TAG_OUT_EN
  localparam int unsigned NumWords = NB_BLOCKS + 2;
`else
  localparam int unsigned NumWords = NB_BLOCKS;
`endif
  localparam int unsigned CntW = $clog2(NumWords + 1);

  typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

  state_e                        state_q, state_d;
  logic [CntW-1:0]               cnt_q, cnt_d;
  logic [NB_BLOCKS*WORD_W-1:0]   cypher_q, cypher_d;
`ifdef CYPHER_TAG_OUT_EN
  logic [127:0]                  tag_q, tag_d;
`else
  logic                          unused_tag;
  assign unused_tag = ^tag_i;
`endif

  logic [WORD_W-1:0] words [NumWords];
  logic [WORD_W-1:0] word_sel;
  logic              accept;
  logic              xfer;
  logic              at_last;

  // Handshake terms depend only on registered state plus ready_i; valid_o never sees ready_i.
  assign accept  = (state_q == StIdle) && load_i;
  assign xfer    = (state_q == StStream) && ready_i;
  assign at_last = (cnt_q == CntW'(NumWords - 1));

  // State register and datapath registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      cypher_q <= '0;
`ifdef CYPHER_TAG_OUT_EN
      tag_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cypher_q <= cypher_d;
`ifdef CYPHER_TAG_OUT_EN
      tag_q    <= tag_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (load_i) state_d = StStream;
      StStream: if (ready_i && at_last) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Snapshot buffer and word counter.
  always_comb begin
    cnt_d    = cnt_q;
    cypher_d = cypher_q;
`ifdef CYPHER_TAG_OUT_EN
    tag_d    = tag_q;
`endif
    if (accept) begin
      cnt_d    = '0;
      cypher_d = cypher_i;
`ifdef CYPHER_TAG_OUT_EN
      tag_d    = tag_i;
`endif
    end else if (xfer) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Flatten the buffer into stream order, then select the word pointed at by the counter.
  always_comb begin
    for (int k = 0; k < NB_BLOCKS; k++) begin
      words[k] = cypher_q[k*WORD_W +: WORD_W];
    end
`ifdef CYPHER_TAG_OUT_EN
    words[NB_BLOCKS]     = tag_q[127:64];
    words[NB_BLOCKS + 1] = tag_q[63:0];
`endif
  end

  always_comb begin
    word_sel = '0;
    for (int k = 0; k < NumWords; k++) begin
      if (cnt_q == CntW'(k)) word_sel = words[k];
    end
  end

  // Output logic.
  always_comb begin
    valid_o = (state_q == StStream);
    last_o  = valid_o && at_last;
    busy_o  = (state_q != StIdle);
    done_o  = (state_q == StDone);
    data_o  = valid_o ? word_sel : '0;
  end

endmodule

// File: tb/tb_cypher_stream_reader.sv
module tb_cypher_stream_reader;

`ifdef CYPHER_TAG_OUT_EN
  localparam int NW = 6;
`else
  localparam int NW = 4;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         load_i;
  logic [255:0] cypher_i;
  logic [127:0] tag_i;
  logic         ready_i;
  logic [63:0]  data_o;
  logic         valid_o, last_o, busy_o, done_o;

  logic         load1;
  logic [63:0]  cy1;
  logic         ready1;
  logic [63:0]  data1;
  logic         valid1, last1, busy1, done1;

  always #5 clk = ~clk;

  cypher_stream_reader #(.NB_BLOCKS(4), .WORD_W(64)) u_dut (
    .clock_i (clk),
    .reset_i (rst),
    .load_i  (load_i),
    .cypher_i(cypher_i),
    .tag_i   (tag_i),
    .ready_i (ready_i),
    .data_o  (data_o),
    .valid_o (valid_o),
    .last_o  (last_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  cypher_stream_reader #(.NB_BLOCKS(1), .WORD_W(64)) u_dut1 (
    .clock_i (clk),
    .reset_i (rst),
    .load_i  (load1),
    .cypher_i(cy1),
    .tag_i   (tag_i),
    .ready_i (ready1),
    .data_o  (data1),
    .valid_o (valid1),
    .last_o  (last1),
    .busy_o  (busy1),
    .done_o  (done1)
  );

  typedef struct {
    logic [3:0][63:0] w;
    logic [127:0]     tag;
    logic [7:0]       rdy;
    bit               midload;
  } vec_t;

  vec_t        vecs [3];
  logic [63:0] sb [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load one vector, stream it under the ready pattern, and score every presented word.
  task automatic run_stream(input int idx);
    vec_t v;
    int   got;
    bit   ended;
    logic r;
    v = vecs[idx];
    sb.delete();
    for (int k = 0; k < 4; k++) sb.push_back(v.w[k]);
`ifdef CYPHER_TAG_OUT_EN
    sb.push_back(v.tag[127:64]);
    sb.push_back(v.tag[63:0]);
`endif
    check("idle_before_load", {63'd0, busy_o}, 64'd0);
    cypher_i = v.w;
    tag_i    = v.tag;
    load_i   = 1'b1;
    ready_i  = v.rdy[0];
    tick();
    load_i   = 1'b0;
    cypher_i = '0;
    tag_i    = '0;
    check("valid_after_load", {63'd0, valid_o}, 64'd1);
    check("busy_after_load", {63'd0, busy_o}, 64'd1);
    got   = 0;
    ended = 1'b0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      if (!valid_o) begin
        ended = 1'b1;
        break;
      end
      r       = v.rdy[cyc % 8];
      ready_i = r;
      if (v.midload && cyc == 1) begin
        load_i   = 1'b1;
        cypher_i = {4{64'h5555_5555_5555_5555}};
      end else begin
        load_i   = 1'b0;
        cypher_i = '0;
      end
      if (sb.size() == 0) begin
        check("valid_with_empty_scoreboard", {63'd0, valid_o}, 64'd0);
      end else begin
        check($sformatf("data_v%0d_w%0d", idx, got), data_o, sb[0]);
        check($sformatf("last_v%0d_w%0d", idx, got), {63'd0, last_o},
              {63'd0, sb.size() == 1});
        if (r) begin
          void'(sb.pop_front());
          got++;
        end
      end
      tick();
    end
    load_i = 1'b0;
    if (!ended) check("stream_timeout", 64'd1, 64'd0);
    check("word_count", 64'(got), 64'(NW));
    check("done_pulse", {63'd0, done_o}, 64'd1);
    check("busy_in_done", {63'd0, busy_o}, 64'd1);
    check("last_after_final", {63'd0, last_o}, 64'd0);
    ready_i = 1'b0;
    tick();
    check("done_cleared", {63'd0, done_o}, 64'd0);
    check("busy_cleared", {63'd0, busy_o}, 64'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("no_restart", {63'd0, valid_o}, 64'd0);
    end
  endtask

  initial begin
    vecs[0].w   = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    vecs[0].tag = {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB};
    vecs[0].rdy = 8'hFF;
    vecs[0].midload = 1'b0;
    vecs[1] = vecs[0];
    vecs[1].rdy = 8'b1001_1001;
    vecs[2].w   = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000,
                   64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};
    vecs[2].tag = {64'h1357_9BDF_0246_8ACE, 64'h8000_0000_0000_0001};
    vecs[2].rdy = 8'b0110_1011;
    vecs[2].midload = 1'b1;

    rst = 1'b1; load_i = 1'b0; cypher_i = '0; tag_i = '0; ready_i = 1'b0;
    load1 = 1'b0; cy1 = '0; ready1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_valid", {63'd0, valid_o}, 64'd0);
    check("rst_last", {63'd0, last_o}, 64'd0);
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_done", {63'd0, done_o}, 64'd0);
    check("rst_data", data_o, 64'd0);

    for (int i = 0; i < 3; i++) run_stream(i);

    // Reset after the second transfer aborts the stream with no done pulse.
    cypher_i = vecs[0].w;
    tag_i    = vecs[0].tag;
    load_i   = 1'b1;
    ready_i  = 1'b1;
    tick();
    load_i = 1'b0;
    check("abort_w0", data_o, 64'h1111_1111_1111_1111);
    tick();
    check("abort_w1", data_o, 64'h2222_2222_2222_2222);
    tick();
    rst     = 1'b1;
    ready_i = 1'b0;
    tick();
    rst = 1'b0;
    check("abort_valid", {63'd0, valid_o}, 64'd0);
    check("abort_busy", {63'd0, busy_o}, 64'd0);
    check("abort_done", {63'd0, done_o}, 64'd0);
    tick();
    check("abort_no_done", {63'd0, done_o}, 64'd0);
    run_stream(0);

`ifndef CYPHER_TAG_OUT_EN
    // Single-word message: valid and last together, then the done pulse.
    cy1    = 64'hDEAD_BEEF_CAFE_F00D;
    load1  = 1'b1;
    ready1 = 1'b1;
    tick();
    load1 = 1'b0;
    cy1   = '0;
    check("nb1_valid", {63'd0, valid1}, 64'd1);
    check("nb1_last", {63'd0, last1}, 64'd1);
    check("nb1_data", data1, 64'hDEAD_BEEF_CAFE_F00D);
    tick();
    check("nb1_valid_low", {63'd0, valid1}, 64'd0);
    check("nb1_done", {63'd0, done1}, 64'd1);
    tick();
    check("nb1_done_low", {63'd0, done1}, 64'd0);
    check("nb1_busy_low", {63'd0, busy1}, 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
